// File: rtl/fft_pkg.sv
// Shared defaults and FSM encoding for the FFT engine share scheduler.
// Optional stats counters are enabled with FFT_SHARE_SCHED_STATS_EN.
package fft_pkg;

    localparam int NFFT_DEF = 32;
    localparam int W_DEF    = 16;
    localparam int LOGN_DEF = $clog2(NFFT_DEF);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_LOAD,
        S_DRAIN
    } state_t;

endpackage

// File: rtl/fft_share_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester favoured
// on a tie and moves to the other side whenever a grant is taken.
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_upd,
    output logic [1:0] o_gnt
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        o_gnt = 2'b00;
        if (!ptr_q) begin
            if (i_req[0])      o_gnt = 2'b01;
            else if (i_req[1]) o_gnt = 2'b10;
        end else begin
            if (i_req[1])      o_gnt = 2'b10;
            else if (i_req[0]) o_gnt = 2'b01;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (i_upd && |o_gnt) ptr_d = o_gnt[0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) ptr_q <= 1'b0;
        else          ptr_q <= ptr_d;
    end

endmodule

// File: rtl/fft_share_sched.sv
// Time-shares one FFT/IFFT engine between two block requesters.
// FFT_SHARE_SCHED_STATS_EN adds per-requester completed-block counters.
module fft_share_sched
    import fft_pkg::*;
#(
    parameter int NFFT = NFFT_DEF,
    parameter int W    = W_DEF
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic [1:0]     i_req,
    input  logic [1:0]     i_ifft,
    output logic [1:0]     o_grant,
    input  logic [1:0]     i_valid,
    input  logic [2*W-1:0] i_x_re,
    input  logic [2*W-1:0] i_x_im,
    output logic [1:0]     o_ready,
    output logic [1:0]     o_valid,
    output logic [W-1:0]   o_y_re,
    output logic [W-1:0]   o_y_im,
    output logic [1:0]     o_last,
    output logic           o_eng_start,
    output logic           o_eng_ifft,
    output logic           o_eng_valid,
    output logic [W-1:0]   o_eng_x_re,
    output logic [W-1:0]   o_eng_x_im,
    input  logic           i_eng_ready,
    input  logic           i_eng_valid,
    input  logic [W-1:0]   i_eng_y_re,
    input  logic [W-1:0]   i_eng_y_im,
    input  logic           i_eng_last
`ifdef FFT_SHARE_SCHED_STATS_EN
   ,output logic [15:0]    o_blk_cnt0,
    output logic [15:0]    o_blk_cnt1
`endif
);

    localparam int LOGN = $clog2(NFFT);
    localparam int CW   = LOGN + 1;

    state_t         state_q, state_d;
    logic           owner_q, owner_d;
    logic           ifft_q, ifft_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   y_re_q, y_re_d;
    logic [W-1:0]   y_im_q, y_im_d;
    logic           ovld_q, ovld_d;
    logic           olast_q, olast_d;

    logic [1:0]     arb_gnt;
    logic           arb_upd;
    logic           own_valid;
    logic [W-1:0]   own_x_re;
    logic [W-1:0]   own_x_im;
    logic           accept;
    logic           load_done;
    logic           drain_v;
    logic [1:0]     own_oh;

    assign arb_upd   = (state_q == S_IDLE) && (|i_req);
    assign own_valid = i_valid[owner_q];
    assign own_x_re  = owner_q ? i_x_re[2*W-1:W] : i_x_re[W-1:0];
    assign own_x_im  = owner_q ? i_x_im[2*W-1:W] : i_x_im[W-1:0];
    assign accept    = (state_q == S_LOAD) && own_valid && i_eng_ready;
    assign load_done = accept && (cnt_q == CW'(NFFT - 1));
    assign drain_v   = (state_q == S_DRAIN) && i_eng_valid;
    assign own_oh    = owner_q ? 2'b10 : 2'b01;

    rr_arb2 u_arb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_req   (i_req),
        .i_upd   (arb_upd),
        .o_gnt   (arb_gnt)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (|i_req) state_d = S_START;
            S_START: state_d = S_LOAD;
            S_LOAD:  if (load_done) state_d = S_DRAIN;
            S_DRAIN: if (drain_v && i_eng_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Owner and mode are latched once at grant and frozen for the block.
    always_comb begin
        owner_d = owner_q;
        ifft_d  = ifft_q;
        if (arb_upd) begin
            owner_d = arb_gnt[1];
            ifft_d  = i_ifft[arb_gnt[1]];
        end
        cnt_d = cnt_q;
        if (state_q == S_START) cnt_d = '0;
        else if (accept)        cnt_d = cnt_q + 1'b1;
        ovld_d  = drain_v;
        olast_d = drain_v && i_eng_last;
        y_re_d  = drain_v ? i_eng_y_re : y_re_q;
        y_im_d  = drain_v ? i_eng_y_im : y_im_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            owner_q <= 1'b0;
            ifft_q  <= 1'b0;
            cnt_q   <= '0;
            y_re_q  <= '0;
            y_im_q  <= '0;
            ovld_q  <= 1'b0;
            olast_q <= 1'b0;
        end else begin
            owner_q <= owner_d;
            ifft_q  <= ifft_d;
            cnt_q   <= cnt_d;
            y_re_q  <= y_re_d;
            y_im_q  <= y_im_d;
            ovld_q  <= ovld_d;
            olast_q <= olast_d;
        end
    end

    // Registered results use owner_q, still valid in the IDLE cycle after DRAIN.
    always_comb begin
        o_grant     = (state_q != S_IDLE) ? own_oh : 2'b00;
        o_eng_start = (state_q == S_START);
        o_eng_ifft  = (state_q != S_IDLE) && ifft_q;
        o_eng_valid = (state_q == S_LOAD) && own_valid;
        o_eng_x_re  = (state_q == S_LOAD) ? own_x_re : '0;
        o_eng_x_im  = (state_q == S_LOAD) ? own_x_im : '0;
        o_ready     = ((state_q == S_LOAD) && i_eng_ready) ? own_oh : 2'b00;
        o_valid     = ovld_q ? own_oh : 2'b00;
        o_last      = olast_q ? own_oh : 2'b00;
        o_y_re      = y_re_q;
        o_y_im      = y_im_q;
    end

`ifdef FFT_SHARE_SCHED_STATS_EN
    logic [15:0] blk_cnt0_q, blk_cnt0_d;
    logic [15:0] blk_cnt1_q, blk_cnt1_d;

    always_comb begin
        blk_cnt0_d = blk_cnt0_q;
        blk_cnt1_d = blk_cnt1_q;
        if (olast_q && !owner_q && blk_cnt0_q != 16'hFFFF)
            blk_cnt0_d = blk_cnt0_q + 16'd1;
        if (olast_q && owner_q && blk_cnt1_q != 16'hFFFF)
            blk_cnt1_d = blk_cnt1_q + 16'd1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            blk_cnt0_q <= '0;
            blk_cnt1_q <= '0;
        end else begin
            blk_cnt0_q <= blk_cnt0_d;
            blk_cnt1_q <= blk_cnt1_d;
        end
    end

    assign o_blk_cnt0 = blk_cnt0_q;
    assign o_blk_cnt1 = blk_cnt1_q;
`endif

endmodule
